// File: rtl/game_pkg.sv
// Shared constants for the key-driven bird game controller: key event codes,
// motion modes, FSM state encoding and bounce direction encoding.
package game_pkg;

  // PS2 key event codes; code 3 is treated the same as KEY_NONE
  localparam logic [1:0] KEY_NONE    = 2'd0;
  localparam logic [1:0] KEY_PRESS   = 2'd1;
  localparam logic [1:0] KEY_RELEASE = 2'd2;

  // Motion modes
  localparam int unsigned MODE_BOUNCE  = 0;
  localparam int unsigned MODE_GRAVITY = 1;

  // Handshake FSM states
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t ACK  = 1'b1;

  // Bounce direction
  typedef logic dir_t;
  localparam dir_t DIR_DOWN = 1'b0;
  localparam dir_t DIR_UP   = 1'b1;

endpackage : game_pkg

// File: rtl/game_score_counter.sv
// Score counter with increment and synchronous clear.
// Build option: KEY_GAME_SCORE_BCD_EN selects a packed-BCD counter
// (SCORE_W/4 digits, all-9s wraps to 0); otherwise plain binary wrap.
module game_score_counter #(
  parameter int unsigned SCORE_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc,
  input  logic               clear,
  output logic [SCORE_W-1:0] score
);

  logic [SCORE_W-1:0] score_nxt;

`ifdef KEY_GAME_SCORE_BCD_EN
  localparam int unsigned DIGITS = SCORE_W / 4;

  logic carry;

  // Digit-ripple BCD increment: a 9 rolls to 0 and carries into the next digit
  always_comb begin
    score_nxt = score;
    carry     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (score[i*4 +: 4] == 4'd9) begin
          score_nxt[i*4 +: 4] = 4'd0;
        end else begin
          score_nxt[i*4 +: 4] = score[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end
`else
  // Binary increment, wraps naturally at 2^SCORE_W
  always_comb begin
    score_nxt = score + SCORE_W'(1);
  end
`endif

  // Score register; clear has priority over increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      score <= '0;
    end else if (clear) begin
      score <= '0;
    end else if (inc) begin
      score <= score_nxt;
    end
  end

endmodule : game_score_counter

// File: rtl/key_game_ctrl.sv
// Key-press game controller: consumes PS2 key events with a one-cycle
// acknowledge, and owns bird position, score, dead flag and debug LED.
// MODE 0 bounces between bounds on each press; MODE 1 applies gravity ticks
// with flap-on-press and a dead/restart state.
// Build option: KEY_GAME_SCORE_BCD_EN makes the score packed BCD.
module key_game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned Y_W         = 10,
  parameter int unsigned Y_MIN       = 0,
  parameter int unsigned Y_MAX       = 456,
  parameter int unsigned Y_START     = 240,
  parameter int unsigned STEP        = 10,
  parameter int unsigned FLAP_STEP   = 10,
  parameter int unsigned GRAV_STEP   = 2,
  parameter int unsigned GRAV_PERIOD = 1000000,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         key_state,
  output logic               key_ack,
  output logic [Y_W-1:0]     bird_y,
  output logic [SCORE_W-1:0] score,
  output logic               dead,
  output logic               led
);

  // One extra bit so y +/- step never wraps before clamping
  localparam int unsigned YE_W  = Y_W + 1;
  localparam int unsigned CNT_W = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0]   y_d;
  logic             dead_d, led_d, ack_d;
  logic             score_inc, score_clr;

  logic [YE_W-1:0]  y_ext;
  logic [YE_W-1:0]  down_sum;
  logic [YE_W-1:0]  grav_sum;
  logic [Y_W-1:0]   bounce_dn_y, bounce_up_y, grav_y, flap_y;
  logic             tick;

  // Clamped position candidates for every kind of move
  always_comb begin
    y_ext    = {1'b0, bird_y};
    down_sum = y_ext + YE_W'(STEP);
    grav_sum = y_ext + YE_W'(GRAV_STEP);

    if (down_sum >= YE_W'(Y_MAX)) bounce_dn_y = Y_W'(Y_MAX);
    else                          bounce_dn_y = Y_W'(down_sum);

    if (y_ext <= YE_W'(Y_MIN + STEP)) bounce_up_y = Y_W'(Y_MIN);
    else                              bounce_up_y = Y_W'(y_ext - YE_W'(STEP));

    if (grav_sum >= YE_W'(Y_MAX)) grav_y = Y_W'(Y_MAX);
    else                          grav_y = Y_W'(grav_sum);

    if (y_ext <= YE_W'(Y_MIN + FLAP_STEP)) flap_y = Y_W'(Y_MIN);
    else                                   flap_y = Y_W'(y_ext - YE_W'(FLAP_STEP));

    tick = (MODE == MODE_GRAVITY) && !dead && (cnt_q == CNT_W'(GRAV_PERIOD - 1));
  end

  // Next-state and next-output logic for handshake, motion and score
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    y_d       = bird_y;
    dead_d    = dead;
    led_d     = led;
    ack_d     = 1'b0;
    score_inc = 1'b0;
    score_clr = 1'b0;

    // Gravity runs regardless of handshake state while alive
    if ((MODE == MODE_GRAVITY) && !dead) begin
      if (tick) begin
        cnt_d = '0;
        y_d   = grav_y;
        if (grav_y == Y_W'(Y_MAX)) dead_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (key_state == KEY_PRESS) begin
          ack_d   = 1'b1;
          state_d = ACK;
          led_d   = 1'b1;
          if (MODE == MODE_GRAVITY) begin
            if (dead) begin
              y_d       = Y_W'(Y_START);
              score_clr = 1'b1;
              dead_d    = 1'b0;
              cnt_d     = '0;
            end else begin
              // Press overrides a coincident tick; the counter has already restarted
              y_d       = flap_y;
              dead_d    = 1'b0;
              score_inc = 1'b1;
            end
          end else begin
            score_inc = 1'b1;
            if (dir_q == DIR_DOWN) begin
              y_d = bounce_dn_y;
              if (bounce_dn_y == Y_W'(Y_MAX)) dir_d = DIR_UP;
            end else begin
              y_d = bounce_up_y;
              if (bounce_up_y == Y_W'(Y_MIN)) dir_d = DIR_DOWN;
            end
          end
        end else if (key_state == KEY_RELEASE) begin
          ack_d   = 1'b1;
          state_d = ACK;
          led_d   = 1'b0;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_DOWN;
      cnt_q   <= '0;
      bird_y  <= Y_W'(Y_START);
      dead    <= 1'b0;
      led     <= 1'b0;
      key_ack <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      bird_y  <= y_d;
      dead    <= dead_d;
      led     <= led_d;
      key_ack <= ack_d;
    end
  end

  game_score_counter #(
    .SCORE_W (SCORE_W)
  ) u_score (
    .clock (clock),
    .reset (reset),
    .inc   (score_inc),
    .clear (score_clr),
    .score (score)
  );

endmodule : key_game_ctrl

// File: tb/tb_key_game_ctrl.sv
// Directed bench for key_game_ctrl: bounce, gravity, handshake, score wrap, reset.
module tb_key_game_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  // dut0: bounce mode, default sizes
  logic [1:0]  ks0 = 2'd0;
  logic        ack0, dead0, led0;
  logic [9:0]  y0;
  logic [15:0] sc0;

  // dut1: gravity mode, fast ticks
  logic [1:0]  ks1 = 2'd0;
  logic        ack1, dead1, led1;
  logic [9:0]  y1;
  logic [15:0] sc1;

  // dut2: bounce mode, narrow score for wrap checks
  logic [1:0]  ks2 = 2'd0;
  logic        ack2, dead2, led2;
  logic [9:0]  y2;
  logic [7:0]  sc2;

  int n_pass  = 0;
  int n_total = 0;

  key_game_ctrl dut0 (
    .clock(clock), .reset(reset), .key_state(ks0), .key_ack(ack0),
    .bird_y(y0), .score(sc0), .dead(dead0), .led(led0)
  );

  key_game_ctrl #(.MODE(1), .GRAV_PERIOD(4), .GRAV_STEP(2)) dut1 (
    .clock(clock), .reset(reset), .key_state(ks1), .key_ack(ack1),
    .bird_y(y1), .score(sc1), .dead(dead1), .led(led1)
  );

  key_game_ctrl #(.SCORE_W(8)) dut2 (
    .clock(clock), .reset(reset), .key_state(ks2), .key_ack(ack2),
    .bird_y(y2), .score(sc2), .dead(dead2), .led(led2)
  );

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ks0 = 2'd0; ks1 = 2'd0; ks2 = 2'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press0();
    ks0 = 2'd1;
    @(negedge clock);
    ks0 = 2'd0;
    @(negedge clock);
  endtask

  task automatic press2();
    ks2 = 2'd1;
    @(negedge clock);
    ks2 = 2'd0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (y0 !== 10'd240) $display("FAIL reset_y0 got %0d exp 240", y0); else n_pass++;
    n_total++; if (sc0 !== 16'd0) $display("FAIL reset_score0 got %0d exp 0", sc0); else n_pass++;
    n_total++; if ({ack0, dead0, led0} !== 3'b000) $display("FAIL reset_flags0 got %b exp 000", {ack0, dead0, led0}); else n_pass++;
    n_total++; if (y1 !== 10'd240 || dead1 !== 1'b0) $display("FAIL reset_dut1 got y=%0d dead=%b exp 240/0", y1, dead1); else n_pass++;
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 21; i++) press0();
    n_total++; if (y0 !== 10'd450 || sc0 !== 16'd21) $display("FAIL bounce_pre got y=%0d sc=%0d exp 450/21", y0, sc0); else n_pass++;
    ks0 = 2'd1;
    @(negedge clock);
    ks0 = 2'd0;
    n_total++; if (ack0 !== 1'b1) $display("FAIL bounce_ack_hi got %b exp 1", ack0); else n_pass++;
    n_total++; if (y0 !== 10'd456 || sc0 !== 16'd22) $display("FAIL bounce_clamp_max got y=%0d sc=%0d exp 456/22", y0, sc0); else n_pass++;
    @(negedge clock);
    n_total++; if (ack0 !== 1'b0) $display("FAIL bounce_ack_lo got %b exp 0", ack0); else n_pass++;
    press0();
    n_total++; if (y0 !== 10'd446) $display("FAIL bounce_dir_up got %0d exp 446", y0); else n_pass++;
    for (int i = 0; i < 44; i++) press0();
    n_total++; if (y0 !== 10'd6) $display("FAIL bounce_near_top got %0d exp 6", y0); else n_pass++;
    press0();
    n_total++; if (y0 !== 10'd0) $display("FAIL bounce_clamp_min got %0d exp 0", y0); else n_pass++;
    press0();
    n_total++; if (y0 !== 10'd10 || led0 !== 1'b1) $display("FAIL bounce_dir_down got y=%0d led=%b exp 10/1", y0, led0); else n_pass++;
  endtask

  task automatic test_release();
    int acks;
    do_reset();
    press0();
    n_total++; if (led0 !== 1'b1) $display("FAIL led_on got %b exp 1", led0); else n_pass++;
    acks = 0;
    ks0 = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (ack0 === 1'b1) acks++;
    end
    ks0 = 2'd0;
    @(negedge clock);
    n_total++; if (led0 !== 1'b0) $display("FAIL led_off got %b exp 0", led0); else n_pass++;
    n_total++; if (acks !== 2) $display("FAIL release_ack_count got %0d exp 2", acks); else n_pass++;
    acks = 0;
    ks0 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (ack0 === 1'b1) acks++;
    end
    ks0 = 2'd0;
    n_total++; if (acks !== 0) $display("FAIL code3_ack_count got %0d exp 0", acks); else n_pass++;
    n_total++; if (sc0 !== 16'd1 || y0 !== 10'd250) $display("FAIL code3_no_effect got sc=%0d y=%0d exp 1/250", sc0, y0); else n_pass++;
  endtask

  task automatic test_gravity_dead();
    int budget;
    do_reset();
    for (int i = 0; i < 8; i++) @(negedge clock);
    n_total++; if (y1 !== 10'd244) $display("FAIL grav_fall got %0d exp 244", y1); else n_pass++;
    budget = 0;
    while (dead1 !== 1'b1 && budget < 1000) begin
      @(negedge clock);
      budget++;
    end
    n_total++; if (dead1 !== 1'b1) $display("FAIL grav_dead got %b exp 1", dead1); else n_pass++;
    n_total++; if (y1 !== 10'd456) $display("FAIL grav_dead_y got %0d exp 456", y1); else n_pass++;
    for (int i = 0; i < 10; i++) @(negedge clock);
    n_total++; if (y1 !== 10'd456 || dead1 !== 1'b1) $display("FAIL grav_frozen got y=%0d dead=%b exp 456/1", y1, dead1); else n_pass++;
    ks1 = 2'd1;
    @(negedge clock);
    ks1 = 2'd0;
    n_total++; if (y1 !== 10'd240 || sc1 !== 16'd0 || dead1 !== 1'b0 || ack1 !== 1'b1)
      $display("FAIL grav_restart got y=%0d sc=%0d dead=%b ack=%b exp 240/0/0/1", y1, sc1, dead1, ack1); else n_pass++;
    for (int i = 0; i < 3; i++) @(negedge clock);
    n_total++; if (y1 !== 10'd240) $display("FAIL grav_restart_cnt_a got %0d exp 240", y1); else n_pass++;
    @(negedge clock);
    n_total++; if (y1 !== 10'd242) $display("FAIL grav_restart_cnt_b got %0d exp 242", y1); else n_pass++;
  endtask

  task automatic test_flap_tick();
    do_reset();
    // Presses on odd edges 1..31 and on edge 44, which coincides with a tick
    for (int k = 1; k <= 44; k++) begin
      ks1 = (((k % 2) == 1 && k <= 31) || k == 44) ? 2'd1 : 2'd0;
      @(negedge clock);
    end
    ks1 = 2'd0;
    n_total++; if (y1 !== 10'd90) $display("FAIL flap_vs_tick got %0d exp 90", y1); else n_pass++;
    n_total++; if (sc1 !== 16'd17) $display("FAIL flap_score got %0d exp 17", sc1); else n_pass++;
    for (int i = 0; i < 3; i++) @(negedge clock);
    n_total++; if (y1 !== 10'd90) $display("FAIL flap_cnt_a got %0d exp 90", y1); else n_pass++;
    @(negedge clock);
    n_total++; if (y1 !== 10'd92) $display("FAIL flap_cnt_b got %0d exp 92", y1); else n_pass++;
  endtask

  task automatic test_score_wrap();
    do_reset();
`ifdef KEY_GAME_SCORE_BCD_EN
    for (int i = 0; i < 19; i++) press2();
    n_total++; if (sc2 !== 8'h19) $display("FAIL bcd_19 got %h exp 19", sc2); else n_pass++;
    press2();
    n_total++; if (sc2 !== 8'h20) $display("FAIL bcd_carry got %h exp 20", sc2); else n_pass++;
    for (int i = 0; i < 79; i++) press2();
    n_total++; if (sc2 !== 8'h99) $display("FAIL bcd_99 got %h exp 99", sc2); else n_pass++;
    press2();
    n_total++; if (sc2 !== 8'h00) $display("FAIL bcd_wrap got %h exp 00", sc2); else n_pass++;
`else
    for (int i = 0; i < 255; i++) press2();
    n_total++; if (sc2 !== 8'hFF) $display("FAIL bin_ff got %h exp ff", sc2); else n_pass++;
    press2();
    n_total++; if (sc2 !== 8'h00) $display("FAIL bin_wrap got %h exp 00", sc2); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_ack();
    do_reset();
    ks0 = 2'd1;
    @(posedge clock);
    #1;
    ks0 = 2'd0;
    n_total++; if (ack0 !== 1'b1 || y0 !== 10'd250) $display("FAIL midack_pre got ack=%b y=%0d exp 1/250", ack0, y0); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (ack0 !== 1'b0) $display("FAIL midack_ack got %b exp 0", ack0); else n_pass++;
    n_total++; if (y0 !== 10'd240 || sc0 !== 16'd0 || led0 !== 1'b0)
      $display("FAIL midack_outputs got y=%0d sc=%0d led=%b exp 240/0/0", y0, sc0, led0); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_total++; if (ack0 !== 1'b0 || sc0 !== 16'd0) $display("FAIL midack_lost got ack=%b sc=%0d exp 0/0", ack0, sc0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_release();
    test_gravity_dead();
    test_flap_tick();
    test_score_wrap();
    test_reset_mid_ack();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_key_game_ctrl
